// File: rtl/serializer_with_counter_pkg.sv
// Shared FSM encodings, width helper and default geometry for the frame serializer.
// Pure declarations: no logic, no latency, no flow control.
package serializer_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] START = 3'd2;
  localparam logic [2:0] SHIFT = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  localparam int DEF_DATA_LENGTH = 16;
  localparam int DEF_WORD_SIZE   = 8;
  localparam int DEF_WORDS       = DEF_DATA_LENGTH / DEF_WORD_SIZE;
  localparam int DEF_BIT_CNT_W   = clog2(DEF_WORD_SIZE) + 1;
  localparam int DEF_WORD_CNT_W  = clog2(DEF_WORDS) + 1;

endpackage

// File: rtl/serializer_with_counter_if.sv
// Word-side handshake plus serial-line status bundle between producer and serializer.
// Wires only; the word_valid/word_ready pair carries the backpressure.
interface serializer_with_counter_if #(
  parameter int WORD_SIZE = 8
);
  logic                 start;
  logic [WORD_SIZE-1:0] data_in;
  logic                 word_valid;
  logic                 word_ready;
  logic                 serial_out;
  logic                 busy;
  logic                 RCO;
  logic                 done;
  logic                 underrun;

  modport master (
    output start, data_in, word_valid,
    input  word_ready, serial_out, busy, RCO, done, underrun
  );

  modport slave (
    input  start, data_in, word_valid,
    output word_ready, serial_out, busy, RCO, done, underrun
  );
endinterface

// File: rtl/serializer_with_counter_word_holding_buffer.sv
// One-entry word register with full flag; rd_dat bypasses to wr_dat while empty.
// Write lands next edge when empty; writes while full are dropped (caller gates ready).
module word_holding_buffer
  import serializer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             take,
  output logic             full,
  output logic [WIDTH-1:0] rd_dat
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] dat_q, dat_d;

  always_comb begin
    full_d = full_q;
    dat_d  = dat_q;
    if (flush) begin
      full_d = 1'b0;
    end else if (take && full_q) begin
      full_d = 1'b0;
    end else if (wr_vld && !full_q) begin
      full_d = 1'b1;
      dat_d  = wr_dat;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      full_q <= 1'b0;
      dat_q  <= '0;
    end else begin
      full_q <= full_d;
      dat_q  <= dat_d;
    end
  end

  assign full   = full_q;
  assign rd_dat = full_q ? dat_q : wr_dat;

endmodule

// File: rtl/serializer_with_counter.sv
// Frame serializer: start bit, DATA_LENGTH bits LSB-first from WORD_SIZE words, stop cycle.
// Start bit one cycle after first-word handshake; an empty buffer at a word boundary aborts the frame.
module serializer_with_counter
  import serializer_pkg::*;
#(
  parameter int   DATA_LENGTH = 16,
  parameter int   WORD_SIZE   = 8,
  parameter logic START_BIT   = 1'b0,
  parameter logic IDLE_BIT    = 1'b1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  serializer_with_counter_if.slave  bus
);

  localparam int WORDS      = DATA_LENGTH / WORD_SIZE;
  localparam int BIT_CNT_W  = clog2(WORD_SIZE) + 1;
  localparam int WORD_CNT_W = clog2(WORDS) + 1;

  logic [2:0]            state_q, state_d;
  logic [WORD_SIZE-1:0]  sreg_q, sreg_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WORD_CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic                  serial_q, serial_d;

  logic                  word_ready;
  logic                  hs;
  logic                  last_bit;
  logic                  more_words;
  logic                  boundary;
  logic                  bypass;
  logic                  buf_take;
  logic                  buf_wr;
  logic                  buf_full;
  logic                  underrun;
  logic [WORD_SIZE-1:0]  next_word;

  always_comb begin
    word_ready = 1'b0;
    case (state_q)
      LOAD:          word_ready = 1'b1;
      START, SHIFT:  word_ready = !buf_full;
      default:       word_ready = 1'b0;
    endcase
  end

  assign hs         = bus.word_valid && word_ready;
  assign last_bit   = (state_q == SHIFT) && (bit_cnt_q == BIT_CNT_W'(WORD_SIZE - 1));
  assign more_words = (word_cnt_q != WORD_CNT_W'(WORDS - 1));
  assign boundary   = last_bit && more_words;
  assign bypass     = boundary && !buf_full && hs;
  assign buf_take   = boundary && buf_full;
  assign underrun   = boundary && !buf_full && !hs;
  // A handshake at the boundary with an empty buffer feeds the shifter directly, never the buffer.
  assign buf_wr     = hs && ((state_q == START) || (state_q == SHIFT)) && !bypass;

  word_holding_buffer #(
    .WIDTH (WORD_SIZE)
  ) u_buf (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (underrun),
    .wr_vld  (buf_wr),
    .wr_dat  (bus.data_in),
    .take    (buf_take),
    .full    (buf_full),
    .rd_dat  (next_word)
  );

  // serial_q is one bit behind sreg_q: each cycle decides the level shown on the next.
  always_comb begin
    state_d    = state_q;
    sreg_d     = sreg_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    serial_d   = IDLE_BIT;
    case (state_q)
      IDLE: begin
        bit_cnt_d  = '0;
        word_cnt_d = '0;
        if (bus.start) state_d = LOAD;
      end
      LOAD: begin
        if (hs) begin
          sreg_d   = bus.data_in;
          serial_d = START_BIT;
          state_d  = START;
        end
      end
      START: begin
        serial_d   = sreg_q[0];
        sreg_d     = sreg_q >> 1;
        bit_cnt_d  = '0;
        word_cnt_d = '0;
        state_d    = SHIFT;
      end
      SHIFT: begin
        if (!last_bit) begin
          serial_d  = sreg_q[0];
          sreg_d    = sreg_q >> 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
        end else if (!more_words) begin
          state_d = STOP;
        end else if (buf_full || hs) begin
          serial_d   = next_word[0];
          sreg_d     = next_word >> 1;
          bit_cnt_d  = '0;
          word_cnt_d = word_cnt_q + 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      STOP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      sreg_q     <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      serial_q   <= IDLE_BIT;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      serial_q   <= serial_d;
    end
  end

  assign bus.word_ready = word_ready;
  assign bus.serial_out = serial_q;
  assign bus.busy       = (state_q != IDLE) || bus.start;
  assign bus.RCO        = last_bit;
  assign bus.done       = (state_q == STOP);
  assign bus.underrun   = underrun;

endmodule

// File: tb/tb_serializer_with_counter.sv
// Directed bench for serializer_with_counter: 16-bit frames of two 8-bit words.
// Line/status traces are recorded per cycle and compared to hand-built frame images.
module tb_serializer_with_counter;

  logic clock = 1'b0;
  logic reset_n;

  serializer_with_counter_if #(.WORD_SIZE(8)) bus ();

  serializer_with_counter #(
    .DATA_LENGTH (16),
    .WORD_SIZE   (8),
    .START_BIT   (1'b0),
    .IDLE_BIT    (1'b1)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  bit          rec = 1'b0;
  int          rec_n = 0;
  logic [63:0] line_v, rco_v, done_v, und_v, busy_v;

  always @(negedge clock) begin
    if (!rec) begin
      rec_n  <= 0;
      line_v <= '0;
      rco_v  <= '0;
      done_v <= '0;
      und_v  <= '0;
      busy_v <= '0;
    end else if (rec_n < 64) begin
      line_v[rec_n] <= bus.serial_out;
      rco_v[rec_n]  <= bus.RCO;
      done_v[rec_n] <= bus.done;
      und_v[rec_n]  <= bus.underrun;
      busy_v[rec_n] <= bus.busy;
      rec_n         <= rec_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Offer one word after dly idle cycles and hold it until accepted.
  task automatic push_word(input logic [7:0] w, input int dly);
    bit hs;
    hs = 1'b0;
    repeat (dly) begin
      @(posedge clock); #1;
    end
    bus.data_in    = w;
    bus.word_valid = 1'b1;
    for (int k = 0; k < 50 && !hs; k++) begin
      @(negedge clock);
      hs = bus.word_ready;
      @(posedge clock); #1;
    end
    bus.word_valid = 1'b0;
    if (!hs) check("hs_timeout", 32'(hs), 32'd1);
  endtask

  // Cycle 0 of the trace is the start cycle; the start bit lands at cycle 2+d0.
  task automatic run_frame(input logic [7:0] w0, input logic [7:0] w1, input int d0, input int d1,
                           input bit two, input bit abuse);
    bit ended;
    @(posedge clock); #1;
    rec       = 1'b1;
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    push_word(w0, d0);
    if (two) push_word(w1, d1);
    ended = 1'b0;
    for (int k = 0; k < 60 && !ended; k++) begin
      @(negedge clock);
      if (bus.done || bus.underrun) ended = 1'b1;
      @(posedge clock); #1;
      bus.start = abuse && (k == 2);
    end
    bus.start = 1'b0;
    if (!ended) check("frame_end_timeout", 32'(ended), 32'd1);
    @(posedge clock); #1;
    rec = 1'b0;
  endtask

  // Receiver model: rebuild each word from the line, LSB first, and expect RCO on its last bit.
  task automatic rx_check(input string tag, input int base, input logic [7:0] w0, input logic [7:0] w1);
    logic [7:0] wd;
    for (int j = 0; j < 2; j++) begin
      wd = line_v[base + 1 + 8 * j +: 8];
      check({tag, "_word"}, 32'(wd), 32'((j == 0) ? w0 : w1));
      check({tag, "_rco"}, 32'(rco_v[base + 8 + 8 * j]), 32'd1);
    end
    check({tag, "_startbit"}, 32'(line_v[base]), 32'd0);
    check({tag, "_stop"}, 32'(line_v[base + 17]), 32'd1);
  endtask

  initial begin
    reset_n        = 1'b1;
    bus.start      = 1'b0;
    bus.word_valid = 1'b0;
    bus.data_in    = '0;
    #2 reset_n = 1'b0;
    #1;
    check("rst_line", 32'(bus.serial_out), 32'd1);
    check("rst_ready", 32'(bus.word_ready), 32'd0);
    check("rst_rco", 32'(bus.RCO), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_underrun", 32'(bus.underrun), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    // Normal frame A5, 3C
    run_frame(8'hA5, 8'h3C, 0, 0, 1'b1, 1'b0);
    check("n_busy_on_start", 32'(busy_v[0]), 32'd1);
    check("n_pre_line", 32'(line_v[1:0]), 32'h3);
    check("n_line", 32'(line_v[2 +: 18]), 32'({1'b1, 8'h3C, 8'hA5, 1'b0}));
    check("n_rco", 32'(rco_v[2 +: 18]), 32'h10100);
    check("n_done", 32'(done_v[2 +: 18]), 32'h20000);
    check("n_underrun", und_v[31:0], 32'd0);
    check("n_busy_after", 32'(busy_v[20]), 32'd0);

    // Loopback frame 1
    run_frame(8'hFF, 8'h00, 0, 0, 1'b1, 1'b0);
    rx_check("lb1", 2, 8'hFF, 8'h00);

    // Second word arrives exactly on the bit-8 cycle: bypass keeps the line continuous
    run_frame(8'hA5, 8'h3C, 0, 8, 1'b1, 1'b0);
    check("late_line", 32'(line_v[2 +: 18]), 32'({1'b1, 8'h3C, 8'hA5, 1'b0}));
    check("late_rco", 32'(rco_v[2 +: 18]), 32'h10100);
    check("late_done", 32'(done_v[19]), 32'd1);
    check("late_underrun", und_v[31:0], 32'd0);

    // Second word never comes: abort at bit 8
    run_frame(8'hA5, 8'h00, 0, 0, 1'b0, 1'b0);
    check("ur_line", 32'(line_v[2 +: 10]), 32'({1'b1, 8'hA5, 1'b0}));
    check("ur_pulse", 32'(und_v[2 +: 10]), 32'h100);
    check("ur_rco", 32'(rco_v[10]), 32'd1);
    check("ur_busy_after", 32'(busy_v[11]), 32'd0);
    check("ur_no_done", done_v[31:0], 32'd0);

    // First word withheld for 5 cycles
    run_frame(8'h12, 8'h34, 5, 0, 1'b1, 1'b0);
    check("dly_idle_line", 32'(line_v[0 +: 7]), 32'h7F);
    check("dly_busy", 32'(busy_v[0 +: 7]), 32'h7F);
    check("dly_line", 32'(line_v[7 +: 18]), 32'({1'b1, 8'h34, 8'h12, 1'b0}));
    check("dly_done", 32'(done_v[24]), 32'd1);

    // word_valid held in IDLE, then start pulsed mid-frame
    bus.data_in    = 8'h55;
    bus.word_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("ab_idle_ready", 32'(bus.word_ready), 32'd0);
      check("ab_idle_busy", 32'(bus.busy), 32'd0);
    end
    @(posedge clock); #1;
    run_frame(8'hA5, 8'h3C, 0, 0, 1'b1, 1'b1);
    check("ab_line", 32'(line_v[2 +: 18]), 32'({1'b1, 8'h3C, 8'hA5, 1'b0}));
    check("ab_rco", 32'(rco_v[2 +: 18]), 32'h10100);
    check("ab_done", 32'(done_v[2 +: 18]), 32'h20000);
    check("ab_busy_after", 32'(busy_v[20]), 32'd0);

    // Reset asserted while data bit 5 is on the line
    @(posedge clock); #1;
    bus.start = 1'b1;
    @(posedge clock); #1;
    bus.start      = 1'b0;
    bus.data_in    = 8'hA5;
    bus.word_valid = 1'b1;
    @(posedge clock); #1;
    bus.data_in = 8'h3C;
    @(posedge clock); #1;
    bus.word_valid = 1'b0;
    repeat (4) begin
      @(posedge clock); #1;
    end
    check("rs_pre_line", 32'(bus.serial_out), 32'd0);
    check("rs_pre_busy", 32'(bus.busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rs_line", 32'(bus.serial_out), 32'd1);
    check("rs_busy", 32'(bus.busy), 32'd0);
    check("rs_ready", 32'(bus.word_ready), 32'd0);
    check("rs_rco", 32'(bus.RCO), 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;

    // Fresh frame after reset, also loopback frame 2
    run_frame(8'h81, 8'h7E, 0, 0, 1'b1, 1'b0);
    rx_check("lb2", 2, 8'h81, 8'h7E);
    check("lb2_line", 32'(line_v[2 +: 18]), 32'({1'b1, 8'h7E, 8'h81, 1'b0}));
    check("lb2_done", 32'(done_v[19]), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
